riscv_dmem_rmw_bridge: RTL and testbench
========================================

Name: riscv_dmem_rmw_bridge

Overview:
- Responder on the core's D-memory port. It sits between RISCV_TOP's D_MEM_* initiator signals and a word-only single-port SRAM macro that has no byte-write enables.
- Full-word reads and writes pass straight through.
- Sub-word stores (byte or halfword lanes) are done as a read-modify-write (RMW): one SRAM read, merge, one SRAM write.
- D_MEM_STALL holds the core for the one extra cycle an RMW needs.

Parameters:
- AWIDTH, 12, word address width on both sides.
- DWIDTH, 32, data width; must be 32 (4 byte lanes).

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RSTn  in  1  reset, synchronous, active-low.
- D_MEM_CSN  in  1  core chip select, active-low.
- D_MEM_WEN  in  1  core write enable, active-low (0=store, 1=load).
- D_MEM_BE  in  4  core byte-lane enables, active-high; bit i selects DI[8i+7:8i].
- D_MEM_ADDR  in  AWIDTH  core word address.
- D_MEM_DI  in  32  store data from core.
- D_MEM_DOUT  out  32  load data to core.
- D_MEM_STALL  out  1  core must hold its request unchanged while 1.
- S_CSN  out  1  SRAM chip select, active-low.
- S_WEN  out  1  SRAM write enable, active-low, whole word.
- S_ADDR  out  AWIDTH  SRAM address.
- S_DI  out  32  SRAM write data.
- S_DOUT  in  32  SRAM read data; valid the cycle after a read is issued.

Behaviour:

States:
- IDLE, RMW_WR.
- ERR state exists only with the optional feature.

Reset (RSTn=0 at a clock edge):
- state=IDLE, D_MEM_STALL=0.
- Holding registers cleared: rmw_addr=0, rmw_data=0, rmw_be=0, rd_pend=0, rd_hold=0.
- D_MEM_DOUT=0.
- S_CSN=1 combinationally while RSTn=0.

IDLE, request present (D_MEM_CSN=0):
- Load (WEN=1): S_CSN=0, S_WEN=1, S_ADDR=D_MEM_ADDR. Set rd_pend=1. Next cycle D_MEM_DOUT=S_DOUT (latency 1, same as SP_SRAM).
- Full store (WEN=0, BE=4'b1111): S_CSN=0, S_WEN=0, S_DI=D_MEM_DI. Zero stall.
- Partial store (WEN=0, BE not 1111 and not 0000):
  - Issue SRAM read of D_MEM_ADDR (S_WEN=1).
  - Latch ADDR, DI and BE.
  - Go to RMW_WR. D_MEM_STALL stays 0 in this acceptance cycle.
- Null store (WEN=0, BE=0000): S_CSN=1, no access, no stall.

IDLE, no request (D_MEM_CSN=1):
- S_CSN=1.

RMW_WR (exactly 1 cycle):
- D_MEM_STALL=1. The core request presented this cycle is ignored and must be re-presented next cycle.
- S_CSN=0, S_WEN=0, S_ADDR=rmw_addr.
- S_DI lane i = rmw_be[i] ? rmw_data lane i : S_DOUT lane i.
- Then return to IDLE.

D_MEM_DOUT:
- Equals S_DOUT in the cycle after a load issue (rd_pend=1); that value is captured into rd_hold.
- Otherwise D_MEM_DOUT=rd_hold. It never shows RMW read data.

Ordering and boundaries:
- Load to the same address right after a partial store: the stall delays it to the cycle after RMW_WR, so it returns merged data.
- Back-to-back partial stores: each costs exactly 1 stall cycle.
- Address wrap: S_ADDR is D_MEM_ADDR[AWIDTH-1:0]; no range check.
- Reset asserted during RMW_WR: the write is dropped (S_CSN=1), state goes to IDLE, stall clears next cycle.
- D_MEM_STALL is never asserted for loads, full stores or idle cycles.

Optional Feature:

Macro: RISCV_DMEM_BE_CHECK_EN

Defined:
- Adds output D_MEM_ERR (1 bit, reset 0).
- Legal partial BE patterns: 0001, 0010, 0100, 1000, 0011, 1100.
- A store with any other non-zero, non-1111 BE:
  - is dropped, with no SRAM access;
  - sets D_MEM_ERR=1 for exactly one cycle, the cycle after acceptance;
  - causes no stall.

Not defined:
- No D_MEM_ERR port.
- Any non-zero BE is merged lane-by-lane as given.

Test Plan:
1. Reset, then hold RSTn=0 for 3 cycles with CSN=0 -> S_CSN=1, D_MEM_DOUT=0, STALL=0 throughout.
2. Full store ADDR=0x010, DI=0xDEADBEEF, BE=1111; then load 0x010 -> one SRAM write, no stall; D_MEM_DOUT=0xDEADBEEF one cycle after the load issue.
3. Memory word 0x11223344 at 0x020; byte store BE=0010, DI=0x0000AA00 -> SRAM read, then STALL=1 for 1 cycle with S_DI=0x1122AA44; a following load of 0x020 returns 0x1122AA44.
4. Two consecutive halfword stores to 0x030 (BE=0011 DI=0x0000BEEF, then BE=1100 DI=0xCAFE0000) over 0x00000000 -> 2 stall cycles total; final word 0xCAFEBEEF.
5. Reset asserted in the RMW_WR cycle of a BE=0001 store to 0x040 holding 0x55555555 -> no SRAM write; the word stays 0x55555555.
6. With RISCV_DMEM_BE_CHECK_EN: store BE=0101 to 0x050 -> D_MEM_ERR pulses 1 cycle, no SRAM access. Without the macro: the same store merges lanes 0 and 2.

Source files
------------

// File: rtl/riscv_dmem_rmw_bridge.sv
// riscv_dmem_rmw_bridge
// Responder on the core D-memory port, driving a word-only single-port SRAM
// that has no byte-write enables. Full-word loads and stores pass straight
// through. A sub-word store becomes a read-modify-write: one SRAM read in the
// acceptance cycle, then one merged SRAM write in RMW_WR. The core is stalled
// for that one extra cycle.
//
// Optional feature: define RISCV_DMEM_BE_CHECK_EN to enable byte-enable
// checking. It adds the D_MEM_ERR output. A store whose byte-enable pattern is
// not a single byte or an aligned halfword is dropped and flagged on D_MEM_ERR.

module riscv_dmem_rmw_bridge #(
    parameter int AWIDTH = 12,
    parameter int DWIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    input  logic                  D_MEM_CSN,
    input  logic                  D_MEM_WEN,
    input  logic [DWIDTH/8-1:0]   D_MEM_BE,
    input  logic [AWIDTH-1:0]     D_MEM_ADDR,
    input  logic [DWIDTH-1:0]     D_MEM_DI,
    output logic [DWIDTH-1:0]     D_MEM_DOUT,
    output logic                  D_MEM_STALL,
    output logic                  S_CSN,
    output logic                  S_WEN,
    output logic [AWIDTH-1:0]     S_ADDR,
    output logic [DWIDTH-1:0]     S_DI,
    input  logic [DWIDTH-1:0]     S_DOUT
`ifdef RISCV_DMEM_BE_CHECK_EN
    ,
    output logic                  D_MEM_ERR
`endif
);

    localparam int NLANE = DWIDTH / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RMW_WR = 2'd1
`ifdef RISCV_DMEM_BE_CHECK_EN
        ,
        ERR    = 2'd2
`endif
    } state_t;

    state_t              state;
    logic [AWIDTH-1:0]   rmw_addr;
    logic [DWIDTH-1:0]   rmw_data;
    logic [NLANE-1:0]    rmw_be;
    logic                rd_pend;
    logic [DWIDTH-1:0]   rd_hold;

    logic                be_all;
    logic                be_none;
    logic                be_legal;
    logic                req;
    logic                acc_load;
    logic                acc_full;
    logic                acc_part;
`ifdef RISCV_DMEM_BE_CHECK_EN
    logic                acc_bad;
`endif
    logic [DWIDTH-1:0]   merged;

    // Classify the incoming core request; nothing is accepted during RMW_WR
    always_comb begin
        be_all  = &D_MEM_BE;
        be_none = ~|D_MEM_BE;
`ifdef RISCV_DMEM_BE_CHECK_EN
        case (D_MEM_BE)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100: be_legal = 1'b1;
            default:          be_legal = 1'b0;
        endcase
`else
        be_legal = 1'b1;
`endif
        req      = (state != RMW_WR) && !D_MEM_CSN;
        acc_load = req && D_MEM_WEN;
        acc_full = req && !D_MEM_WEN && be_all;
        acc_part = req && !D_MEM_WEN && !be_all && !be_none && be_legal;
`ifdef RISCV_DMEM_BE_CHECK_EN
        acc_bad  = req && !D_MEM_WEN && !be_all && !be_none && !be_legal;
`endif
    end

    // Merge the latched store lanes over the word read back from the SRAM
    always_comb begin
        merged = '0;
        for (int unsigned i = 0; i < NLANE; i++) begin
            merged[8*i +: 8] = rmw_be[i] ? rmw_data[8*i +: 8] : S_DOUT[8*i +: 8];
        end
    end

    // SRAM request: merged write in RMW_WR, otherwise pass-through of the core
    always_comb begin
        S_CSN  = 1'b1;
        S_WEN  = 1'b1;
        S_ADDR = D_MEM_ADDR;
        S_DI   = D_MEM_DI;
        if (!RSTn) begin
            S_CSN = 1'b1;
        end else if (state == RMW_WR) begin
            S_CSN  = 1'b0;
            S_WEN  = 1'b0;
            S_ADDR = rmw_addr;
            S_DI   = merged;
        end else if (acc_load || acc_part) begin
            S_CSN = 1'b0;
            S_WEN = 1'b1;
        end else if (acc_full) begin
            S_CSN = 1'b0;
            S_WEN = 1'b0;
        end
    end

    // Load data is live for the cycle after a load issue, then held
    always_comb begin
        D_MEM_DOUT = rd_pend ? S_DOUT : rd_hold;
    end

    // Control FSM with registered stall/error outputs and holding registers
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state       <= IDLE;
            D_MEM_STALL <= 1'b0;
            rmw_addr    <= '0;
            rmw_data    <= '0;
            rmw_be      <= '0;
            rd_pend     <= 1'b0;
            rd_hold     <= '0;
`ifdef RISCV_DMEM_BE_CHECK_EN
            D_MEM_ERR   <= 1'b0;
`endif
        end else begin
            rd_pend     <= acc_load;
            D_MEM_STALL <= acc_part;
            if (rd_pend) begin
                rd_hold <= S_DOUT;
            end
            if (acc_part) begin
                rmw_addr <= D_MEM_ADDR;
                rmw_data <= D_MEM_DI;
                rmw_be   <= D_MEM_BE;
            end
`ifdef RISCV_DMEM_BE_CHECK_EN
            D_MEM_ERR <= acc_bad;
`endif
            case (state)
                RMW_WR: begin
                    state <= IDLE;
                end
                default: begin
                    if (acc_part) begin
                        state <= RMW_WR;
`ifdef RISCV_DMEM_BE_CHECK_EN
                    end else if (acc_bad) begin
                        state <= ERR;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_dmem_rmw_bridge.sv
// Testbench for riscv_dmem_rmw_bridge: table of core transactions over a
// behavioural word SRAM, with a load-data scoreboard plus hand-written
// reset sequences.
module tb_riscv_dmem_rmw_bridge;

    logic        CLK;
    logic        RSTn;
    logic        D_MEM_CSN;
    logic        D_MEM_WEN;
    logic [3:0]  D_MEM_BE;
    logic [11:0] D_MEM_ADDR;
    logic [31:0] D_MEM_DI;
    logic [31:0] D_MEM_DOUT;
    logic        D_MEM_STALL;
    logic        S_CSN;
    logic        S_WEN;
    logic [11:0] S_ADDR;
    logic [31:0] S_DI;
    logic [31:0] S_DOUT;
`ifdef RISCV_DMEM_BE_CHECK_EN
    logic        D_MEM_ERR;
`endif

    riscv_dmem_rmw_bridge #(.AWIDTH(12), .DWIDTH(32)) dut (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .D_MEM_CSN  (D_MEM_CSN),
        .D_MEM_WEN  (D_MEM_WEN),
        .D_MEM_BE   (D_MEM_BE),
        .D_MEM_ADDR (D_MEM_ADDR),
        .D_MEM_DI   (D_MEM_DI),
        .D_MEM_DOUT (D_MEM_DOUT),
        .D_MEM_STALL(D_MEM_STALL),
        .S_CSN      (S_CSN),
        .S_WEN      (S_WEN),
        .S_ADDR     (S_ADDR),
        .S_DI       (S_DI),
        .S_DOUT     (S_DOUT)
`ifdef RISCV_DMEM_BE_CHECK_EN
        ,
        .D_MEM_ERR  (D_MEM_ERR)
`endif
    );

    // Behavioural word SRAM, read latency 1
    logic [31:0] sram [0:4095];
    always @(posedge CLK) begin
        if (!S_CSN) begin
            if (!S_WEN) sram[S_ADDR] <= S_DI;
            else        S_DOUT <= sram[S_ADDR];
        end
    end

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%h required=%h", name, act, exp);
    endtask

    function automatic bit be_ok(input logic [3:0] be);
`ifdef RISCV_DMEM_BE_CHECK_EN
        return (be == 4'b0001) || (be == 4'b0010) || (be == 4'b0100) ||
               (be == 4'b1000) || (be == 4'b0011) || (be == 4'b1100);
`else
        return 1'b1;
`endif
    endfunction

    // Scoreboard of expected load data and monitor state
    logic [31:0] exp_q [$];
    bit          mon_en   = 1'b0;
    bit          ld_prev  = 1'b0;
`ifdef RISCV_DMEM_BE_CHECK_EN
    bit          err_prev = 1'b0;
`endif

    always @(negedge CLK) begin
        if (mon_en) begin
            if (ld_prev) begin
                if (exp_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
                else                   chk("load_data", D_MEM_DOUT, exp_q.pop_front());
            end
`ifdef RISCV_DMEM_BE_CHECK_EN
            chk("err_pulse", {31'd0, D_MEM_ERR}, {31'd0, err_prev});
            err_prev = RSTn && !D_MEM_CSN && !D_MEM_WEN && !D_MEM_STALL &&
                       (D_MEM_BE != 4'b0000) && (D_MEM_BE != 4'b1111) && !be_ok(D_MEM_BE);
`endif
            ld_prev = RSTn && !D_MEM_CSN && D_MEM_WEN && !D_MEM_STALL;
        end
    end

    logic [11:0] pend_addr = '0;
    logic [31:0] pend_data = '0;
    logic [31:0] last_load = '0;

    // Present one request and hold it through any stall until accepted
    task automatic issue(input logic wen, input logic [3:0] be, input logic [11:0] addr,
                         input logic [31:0] di, input logic [31:0] exp, input int unsigned pre);
        int unsigned stalls = 0;
        bit          done   = 1'b0;
        D_MEM_CSN  = 1'b0;
        D_MEM_WEN  = wen;
        D_MEM_BE   = be;
        D_MEM_ADDR = addr;
        D_MEM_DI   = di;
        for (int unsigned k = 0; k < 4 && !done; k++) begin
            @(negedge CLK);
            if (D_MEM_STALL) begin
                stalls++;
                chk("rmw_csn",  {31'd0, S_CSN}, 32'd0);
                chk("rmw_wen",  {31'd0, S_WEN}, 32'd0);
                chk("rmw_addr", {20'd0, S_ADDR}, {20'd0, pend_addr});
                chk("rmw_data", S_DI, pend_data);
                chk("rmw_dout_hold", D_MEM_DOUT, last_load);
            end else begin
                done = 1'b1;
                if (wen) begin
                    chk("ld_csn",  {31'd0, S_CSN}, 32'd0);
                    chk("ld_wen",  {31'd0, S_WEN}, 32'd1);
                    chk("ld_addr", {20'd0, S_ADDR}, {20'd0, addr});
                    exp_q.push_back(exp);
                    last_load = exp;
                end else if (be == 4'b1111) begin
                    chk("wr_csn",  {31'd0, S_CSN}, 32'd0);
                    chk("wr_wen",  {31'd0, S_WEN}, 32'd0);
                    chk("wr_addr", {20'd0, S_ADDR}, {20'd0, addr});
                    chk("wr_data", S_DI, di);
                end else if (be == 4'b0000 || !be_ok(be)) begin
                    chk("drop_csn", {31'd0, S_CSN}, 32'd1);
                end else begin
                    chk("rmw_rd_csn",  {31'd0, S_CSN}, 32'd0);
                    chk("rmw_rd_wen",  {31'd0, S_WEN}, 32'd1);
                    chk("rmw_rd_addr", {20'd0, S_ADDR}, {20'd0, addr});
                    pend_addr = addr;
                    pend_data = exp;
                end
            end
            @(posedge CLK);
            #1;
        end
        chk("accepted", {31'd0, done}, 32'd1);
        chk("stall_cycles", stalls, pre);
        D_MEM_CSN = 1'b1;
    endtask

    typedef struct {
        logic        wen;
        logic [3:0]  be;
        logic [11:0] addr;
        logic [31:0] di;
        logic [31:0] exp;
        int unsigned pre;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    initial begin
        // Preloads, then the main transaction mix
        vecs[0]  = '{1'b0, 4'b1111, 12'h010, 32'hDEADBEEF, 32'hDEADBEEF, 0};
        vecs[1]  = '{1'b1, 4'b1111, 12'h010, 32'h00000000, 32'hDEADBEEF, 0};
        vecs[2]  = '{1'b0, 4'b1111, 12'h020, 32'h11223344, 32'h11223344, 0};
        vecs[3]  = '{1'b0, 4'b1111, 12'h030, 32'h00000000, 32'h00000000, 0};
        vecs[4]  = '{1'b0, 4'b1111, 12'h040, 32'h55555555, 32'h55555555, 0};
        vecs[5]  = '{1'b0, 4'b1111, 12'h050, 32'h77777777, 32'h77777777, 0};
        vecs[6]  = '{1'b0, 4'b1111, 12'h060, 32'h01020304, 32'h01020304, 0};
        vecs[7]  = '{1'b0, 4'b0010, 12'h020, 32'h0000AA00, 32'h1122AA44, 0};
        vecs[8]  = '{1'b1, 4'b1111, 12'h020, 32'h00000000, 32'h1122AA44, 1};
        vecs[9]  = '{1'b0, 4'b0011, 12'h030, 32'h0000BEEF, 32'h0000BEEF, 0};
        vecs[10] = '{1'b0, 4'b1100, 12'h030, 32'hCAFE0000, 32'hCAFEBEEF, 1};
        vecs[11] = '{1'b1, 4'b1111, 12'h030, 32'h00000000, 32'hCAFEBEEF, 1};
        vecs[12] = '{1'b0, 4'b0000, 12'h060, 32'hFFFFFFFF, 32'h00000000, 0};
        vecs[13] = '{1'b1, 4'b1111, 12'h060, 32'h00000000, 32'h01020304, 0};
        vecs[14] = '{1'b0, 4'b0101, 12'h050, 32'h00AA00BB, 32'h77AA77BB, 0};
`ifdef RISCV_DMEM_BE_CHECK_EN
        vecs[15] = '{1'b1, 4'b1111, 12'h050, 32'h00000000, 32'h77777777, 0};
`else
        vecs[15] = '{1'b1, 4'b1111, 12'h050, 32'h00000000, 32'h77AA77BB, 1};
`endif
        vecs[16] = '{1'b0, 4'b1111, 12'hFFF, 32'h0BADF00D, 32'h0BADF00D, 0};
        vecs[17] = '{1'b1, 4'b1111, 12'hFFF, 32'h00000000, 32'h0BADF00D, 0};

        // Reset held with a load request present
        RSTn = 1'b0;
        D_MEM_CSN = 1'b0;
        D_MEM_WEN = 1'b1;
        D_MEM_BE = 4'b1111;
        D_MEM_ADDR = 12'h010;
        D_MEM_DI = '0;
        @(posedge CLK);
        #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("rst_s_csn", {31'd0, S_CSN}, 32'd1);
            chk("rst_stall", {31'd0, D_MEM_STALL}, 32'd0);
            chk("rst_dout",  D_MEM_DOUT, 32'd0);
`ifdef RISCV_DMEM_BE_CHECK_EN
            chk("rst_err",   {31'd0, D_MEM_ERR}, 32'd0);
`endif
        end
        @(posedge CLK);
        #1;
        RSTn = 1'b1;
        D_MEM_CSN = 1'b1;
        mon_en = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            issue(vecs[i].wen, vecs[i].be, vecs[i].addr, vecs[i].di, vecs[i].exp, vecs[i].pre);
        end

        // Idle cycles: no stall, SRAM deselected
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            chk("idle_stall", {31'd0, D_MEM_STALL}, 32'd0);
            chk("idle_csn",   {31'd0, S_CSN}, 32'd1);
        end
        @(posedge CLK);
        #1;

        // Reset arriving in the RMW_WR cycle drops the merged write
        issue(1'b0, 4'b0001, 12'h040, 32'h000000AA, 32'h555555AA, 0);
        RSTn = 1'b0;
        @(negedge CLK);
        chk("rstrmw_stall", {31'd0, D_MEM_STALL}, 32'd1);
        chk("rstrmw_csn",   {31'd0, S_CSN}, 32'd1);
        @(posedge CLK);
        #1;
        RSTn = 1'b1;
        last_load = '0;
        @(negedge CLK);
        chk("rstrmw_stall_clr", {31'd0, D_MEM_STALL}, 32'd0);
        chk("rstrmw_dout",      D_MEM_DOUT, 32'd0);
        @(posedge CLK);
        #1;
        issue(1'b1, 4'b1111, 12'h040, 32'h00000000, 32'h55555555, 0);

        repeat (3) @(negedge CLK);
        chk("sb_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
